// File: rtl/pong_mem_dma.sv
// Avalon-MM block mover between the on-chip memory slave and a pair of
// valid/ready word streams; one command at a time, reads credit-limited by the return FIFO.
module pong_mem_dma #(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] OCC_MAX = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
    logic [LEN_W-1:0]    words_left_q, words_left_d;
    logic [CNT_W-1:0]    in_flight_q, in_flight_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0]    fifo_rd_q, fifo_rd_d;
    logic                avm_read_q, avm_read_d;
    logic                avm_write_q, avm_write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [31:0]         mem_q [FIFO_DEPTH];

    logic                rd_accept_s;
    logic                rd_push_s;
    logic                rd_pop_s;
    logic                rd_valid_s;
    logic                wr_ready_s;
    logic                wr_xfer_s;
    logic                wr_done_s;
    logic [CNT_W:0]      occ_s;
    logic [LEN_W-1:0]    words_after_rd_s;

    assign rd_valid_s  = (fifo_count_q != {CNT_W{1'b0}});
    assign rd_accept_s = avm_read_q & ~avm_waitrequest;
    assign rd_push_s   = avm_readdatavalid & ((state_q == S_READ) | (state_q == S_DRAIN));
    assign rd_pop_s    = rd_valid_s & rd_ready;
    assign wr_ready_s  = (state_q == S_WRITE) & (~avm_write_q | ~avm_waitrequest) &
                         (words_left_q != {LEN_W{1'b0}});
    assign wr_xfer_s   = wr_valid & wr_ready_s;
    assign wr_done_s   = avm_write_q & ~avm_waitrequest;

    // Slots committed to words not yet popped, after this cycle's accept/pop; a
    // read is only requested while a FIFO slot is guaranteed for its data.
    assign occ_s = {1'b0, in_flight_q} + {1'b0, fifo_count_q}
                 + {{CNT_W{1'b0}}, rd_accept_s} - {{CNT_W{1'b0}}, rd_pop_s};
    assign words_after_rd_s = words_left_q - {{(LEN_W-1){1'b0}}, rd_accept_s};

    // Next-state logic for the command FSM, bus request registers and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nxt_addr_d   = nxt_addr_q;
        words_left_d = words_left_q;
        avm_read_d   = avm_read_q;
        avm_write_d  = avm_write_q;
        wdata_d      = wdata_q;

        in_flight_d  = in_flight_q + {{(CNT_W-1){1'b0}}, rd_accept_s}
                                   - {{(CNT_W-1){1'b0}}, rd_push_s};
        fifo_count_d = fifo_count_q + {{(CNT_W-1){1'b0}}, rd_push_s}
                                    - {{(CNT_W-1){1'b0}}, rd_pop_s};
        fifo_wr_d    = rd_push_s ? fifo_wr_q + PTR_W'(1'b1) : fifo_wr_q;
        fifo_rd_d    = rd_pop_s  ? fifo_rd_q + PTR_W'(1'b1) : fifo_rd_q;

        case (state_q)
            S_IDLE: begin
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
                if (cmd_valid) begin
                    nxt_addr_d   = cmd_addr;
                    words_left_d = cmd_len;
                    if (cmd_len == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d    = S_READ;
                        addr_d     = cmd_addr;
                        avm_read_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_accept_s) begin
                    addr_d       = addr_q + ADDR_W'(1'b1);
                    words_left_d = words_after_rd_s;
                end else begin
                    addr_d       = addr_q;
                end
                if (avm_read_q & avm_waitrequest) begin
                    avm_read_d = 1'b1;
                end else begin
                    avm_read_d = (words_after_rd_s != {LEN_W{1'b0}}) && (occ_s < OCC_MAX);
                end
                if (rd_accept_s && (words_after_rd_s == {LEN_W{1'b0}})) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                avm_read_d = 1'b0;
                if ((in_flight_q == {CNT_W{1'b0}}) && (fifo_count_q == {CNT_W{1'b0}})) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_WRITE: begin
                if (wr_xfer_s) begin
                    avm_write_d  = 1'b1;
                    addr_d       = nxt_addr_q;
                    nxt_addr_d   = nxt_addr_q + ADDR_W'(1'b1);
                    wdata_d      = wr_data;
                    words_left_d = words_left_q - LEN_W'(1'b1);
                end else if (wr_done_s) begin
                    avm_write_d = 1'b0;
                end else begin
                    avm_write_d = avm_write_q;
                end
                if (wr_done_s && (words_left_q == {LEN_W{1'b0}})) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_READ) | (state_d == S_DRAIN) | (state_d == S_WRITE);
    end

    // State and control registers; reset abandons any transfer in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            nxt_addr_q   <= {ADDR_W{1'b0}};
            words_left_q <= {LEN_W{1'b0}};
            in_flight_q  <= {CNT_W{1'b0}};
            fifo_count_q <= {CNT_W{1'b0}};
            fifo_wr_q    <= {PTR_W{1'b0}};
            fifo_rd_q    <= {PTR_W{1'b0}};
            avm_read_q   <= 1'b0;
            avm_write_q  <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            nxt_addr_q   <= nxt_addr_d;
            words_left_q <= words_left_d;
            in_flight_q  <= in_flight_d;
            fifo_count_q <= fifo_count_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            avm_read_q   <= avm_read_d;
            avm_write_q  <= avm_write_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // Return-data storage; contents are meaningless while the count is zero.
    always_ff @(posedge clk) begin
        if (rd_push_s) begin
            mem_q[fifo_wr_q] <= avm_readdata;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = 4'hF;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = wdata_q;
    assign rd_data        = mem_q[fifo_rd_q];
    assign rd_valid       = rd_valid_s;
    assign wr_ready       = wr_ready_s;

endmodule

// File: tb/tb_pong_mem_dma.sv
// Directed bench for pong_mem_dma: a memory slave model returning word = address,
// stream drivers/monitors, and one task per scenario with inline checks.
module tb_pong_mem_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [12:0] cmd_len;
    logic        busy, done;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [11:0] rd_acc_addr[$];
    int          rd_acc_cyc[$];
    logic [31:0] rd_got[$];
    logic [11:0] wr_log_addr[$];
    logic [31:0] wr_log_data[$];
    int          wr_log_cyc[$];
    logic [31:0] wr_q[$];
    int          acc_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rw_cnt = 0;
    int          both_cnt = 0;
    int          stall_seen = 0, stall_bad = 0, stall_wrready = 0;

    logic        stall_en = 1'b0;
    logic [11:0] stall_addr = 12'h000;
    int          stall_cnt = 0;
    logic        pend = 1'b0;
    logic [11:0] pend_addr = 12'h000;

    pong_mem_dma #(.ADDR_W(12), .LEN_W(13), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    // Slave and write-stream drivers update shortly after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        avm_readdatavalid = pend;
        avm_readdata      = {20'h00000, pend_addr};
        if (stall_en && (avm_read || avm_write) && avm_address == stall_addr && stall_cnt > 0) begin
            avm_waitrequest = 1'b1;
            stall_cnt = stall_cnt - 1;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (wr_q.size() != 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_q[0];
        end else begin
            wr_valid = 1'b0;
            wr_data  = 32'h0;
        end
    end

    // Monitors sample on the falling edge; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        pend      = avm_read && !avm_waitrequest;
        pend_addr = avm_address;
        if (pend) begin
            rd_acc_addr.push_back(avm_address);
            rd_acc_cyc.push_back(cyc);
        end
        if (avm_write && !avm_waitrequest) begin
            wr_log_addr.push_back(avm_address);
            wr_log_data.push_back(avm_writedata);
            wr_log_cyc.push_back(cyc);
        end
        if (avm_write && avm_waitrequest) begin
            stall_seen = stall_seen + 1;
            if (avm_address !== 12'h101 || avm_writedata !== 32'h0000_000B) stall_bad = stall_bad + 1;
            if (wr_ready !== 1'b0) stall_wrready = stall_wrready + 1;
        end
        if (wr_valid && wr_ready) void'(wr_q.pop_front());
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
        if (avm_read || avm_write) rw_cnt = rw_cnt + 1;
        if (avm_read && avm_write) both_cnt = both_cnt + 1;
    end

    task automatic clear_logs();
        rd_acc_addr.delete(); rd_acc_cyc.delete(); rd_got.delete();
        wr_log_addr.delete(); wr_log_data.delete(); wr_log_cyc.delete();
        acc_cyc.delete();
        rw_cnt = 0; stall_seen = 0; stall_bad = 0; stall_wrready = 0;
    endtask

    task automatic send_cmd(input logic w, input logic [11:0] a, input logic [12:0] l, output int acc);
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        if (acc < 0) begin
            tests_run++; tests_failed++;
            $display("FAIL cmd_accept: command never accepted within 200 cycles");
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        int start;
        int seen;
        start = done_cnt;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt > start) begin
                seen = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (seen == 0 || done_cnt !== start + 1) begin
            tests_failed++;
            $display("FAIL %s_done: done pulses %0d, expected exactly 1", name, done_cnt - start);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, busy, done, avm_read, avm_write, rd_valid, wr_ready} !== 7'b1000000 ||
            avm_address !== 12'h000 || avm_writedata !== 32'h0 || avm_byteenable !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h be=%h, expected ctl=1000000 addr=000 wdata=0 be=F",
                     {cmd_ready, busy, done, avm_read, avm_write, rd_valid, wr_ready},
                     avm_address, avm_writedata, avm_byteenable);
        end
        #20 reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read4();
        int acc;
        int bad;
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'h010, 13'd4, acc);
        wait_done(100, "read4");
        bad = (rd_acc_addr.size() != 4) ? 1 : 0;
        for (int i = 0; i < rd_acc_addr.size() && i < 4; i++)
            if (rd_acc_addr[i] !== 12'h010 + 12'(i) || rd_acc_cyc[i] != rd_acc_cyc[0] + i) bad = 1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL read4_addr_seq: %0d reads issued, first addr %h, expected 010..013 on consecutive cycles",
                     rd_acc_addr.size(), (rd_acc_addr.size() > 0) ? rd_acc_addr[0] : 12'hxxx);
        end
        bad = (rd_got.size() != 4) ? 1 : 0;
        for (int i = 0; i < rd_got.size() && i < 4; i++)
            if (rd_got[i] !== 32'h10 + 32'(i)) bad = 1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL read4_data: got %0d words, expected 4 words 10,11,12,13", rd_got.size());
        end
        tests_run++;
        if (rd_got.size() == 4 && done_cyc <= rd_acc_cyc[0] + 4) begin
            tests_failed++;
            $display("FAIL read4_done_timing: done at cycle %0d, expected after last pop", done_cyc);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int bad;
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 12'h000, 13'd8, acc);
        repeat (10) @(negedge clk);
        tests_run++;
        if (rd_acc_addr.size() != 4 || avm_read !== 1'b0 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_credit_limit: reads=%0d avm_read=%b rd_valid=%b, expected 4 0 1",
                     rd_acc_addr.size(), avm_read, rd_valid);
        end
        @(posedge clk); #2 rd_ready = 1'b1;
        wait_done(200, "bp");
        bad = (rd_got.size() != 8) ? 1 : 0;
        for (int i = 0; i < rd_got.size() && i < 8; i++)
            if (rd_got[i] !== 32'(i)) bad = 1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_data_order: got %0d words, expected 8 words 0..7 in order", rd_got.size());
        end
    endtask

    task automatic test_write();
        int acc;
        int bad;
        clear_logs();
        stall_addr = 12'h101; stall_cnt = 2; stall_en = 1'b1;
        wr_q.push_back(32'hA); wr_q.push_back(32'hB); wr_q.push_back(32'hC);
        send_cmd(1'b1, 12'h100, 13'd3, acc);
        wait_done(100, "write");
        stall_en = 1'b0;
        bad = (wr_log_addr.size() != 3) ? 1 : 0;
        for (int i = 0; i < wr_log_addr.size() && i < 3; i++)
            if (wr_log_addr[i] !== 12'h100 + 12'(i) || wr_log_data[i] !== 32'hA + 32'(i)) bad = 1;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL write_seq: %0d writes, expected (100,A) (101,B) (102,C)", wr_log_addr.size());
        end
        tests_run++;
        if (stall_seen != 2 || stall_bad != 0 || stall_wrready != 0) begin
            tests_failed++;
            $display("FAIL write_stall_hold: stall cycles=%0d unstable=%0d wr_ready_high=%0d, expected 2 0 0",
                     stall_seen, stall_bad, stall_wrready);
        end
        tests_run++;
        if (wr_log_cyc.size() == 3 && done_cyc != wr_log_cyc[2] + 1) begin
            tests_failed++;
            $display("FAIL write_done_timing: done cycle %0d, expected %0d", done_cyc, wr_log_cyc[2] + 1);
        end
    endtask

    task automatic test_wrap();
        int acc;
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'hFFF, 13'd2, acc);
        wait_done(100, "wrap");
        tests_run++;
        if (rd_acc_addr.size() != 2 || rd_acc_addr[0] !== 12'hFFF || rd_acc_addr[1] !== 12'h000 ||
            rd_got.size() != 2 || rd_got[0] !== 32'hFFF || rd_got[1] !== 32'h000) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d reads %0d words, expected addresses FFF then 000",
                     rd_acc_addr.size(), rd_got.size());
        end
    endtask

    task automatic test_zero_len();
        int acc;
        clear_logs();
        send_cmd(1'b0, 12'h055, 13'd0, acc);
        wait_done(20, "zero_len");
        tests_run++;
        if (done_cyc != acc + 1) begin
            tests_failed++;
            $display("FAIL zero_len_timing: done cycle %0d, expected %0d", done_cyc, acc + 1);
        end
        tests_run++;
        if (rw_cnt != 0) begin
            tests_failed++;
            $display("FAIL zero_len_no_bus: bus request cycles %0d, expected 0", rw_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        int ok;
        clear_logs();
        rd_ready = 1'b1;
        d1 = -1;
        ok = 0;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_len = 13'd2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_cyc.size() >= 1) break;
        end
        @(posedge clk); #2;
        cmd_addr = 12'h040; cmd_len = 13'd1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cyc.size() >= 2) begin
                d1 = done_cyc;
                ok = 1;
                break;
            end
        end
        @(posedge clk); #2 cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (ok == 0 || acc_cyc[1] != d1 + 1 || done_cnt < 2) begin
            tests_failed++;
            $display("FAIL b2b_accept: accepts=%0d second at %0d, expected first done cycle+1 = %0d",
                     acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] : -1, d1 + 1);
        end
        tests_run++;
        if (rd_got.size() != 3 || rd_got[0] !== 32'h20 || rd_got[1] !== 32'h21 || rd_got[2] !== 32'h40) begin
            tests_failed++;
            $display("FAIL b2b_data: got %0d words, expected 20 21 40", rd_got.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int dc;
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 12'h200, 13'd8, acc);
        repeat (6) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pre: busy=%b rd_valid=%b, expected 1 1", busy, rd_valid);
        end
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, busy, done, avm_read, avm_write, rd_valid, wr_ready} !== 7'b1000000 ||
            avm_address !== 12'h000 || avm_writedata !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: ctl=%b addr=%h wdata=%h, expected ctl=1000000 addr=000 wdata=0",
                     {cmd_ready, busy, done, avm_read, avm_write, rd_valid, wr_ready}, avm_address, avm_writedata);
        end
        dc = done_cnt;
        @(posedge clk); #3 reset_n = 1'b1;
        rd_ready = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (done_cnt != dc || rd_got.size() != 0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_after: done pulses %0d words %0d cmd_ready %b, expected 0 0 1",
                     done_cnt - dc, rd_got.size(), cmd_ready);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000; cmd_len = 13'd0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
        test_reset();
        test_read4();
        test_backpressure();
        test_write();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        tests_run++;
        if (both_cnt != 0) begin
            tests_failed++;
            $display("FAIL rw_exclusive: %0d cycles with read and write both high, expected 0", both_cnt);
        end
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pong_mem_dma.md
Name: pong_mem_dma

Overview:
- Avalon-MM master that moves 32-bit word blocks between a streaming client (game logic, video fetch) and the single-port on-chip memory slave.
- Accepts one command at a time: base word address, length, direction.
- Read direction: issues pipelined reads and buffers the returned data in an internal FIFO for a valid/ready output stream.
- Write direction: takes words from a valid/ready input stream and issues them as sequential full-word writes.

Parameters:
- ADDR_W, 12, word-address width of the memory slave.
- LEN_W, 13, width of the command length field (0..2^LEN_W-1 words).
- FIFO_DEPTH, 4, read-return FIFO depth in words (power of 2, >=2); also the maximum number of reads in flight.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write memory from the stream; 0 = read memory to the stream.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  number of words.
- busy  out  1  high from the cycle after command accept until the cycle done is asserted.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  constant 4'hF.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data strobe.
- rd_data  out  32  output stream data (FIFO head).
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  output stream ready.
- wr_data  in  32  input stream data.
- wr_valid  in  1  input stream valid.
- wr_ready  out  1  input stream ready.

Behaviour:
- Reset (async, reset_n=0): state IDLE; cmd_ready=1; busy, done, avm_read, avm_write, rd_valid, wr_ready all 0; avm_address and avm_writedata 0; FIFO empty; in-flight count 0.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: a command is accepted on cmd_valid & cmd_ready. At accept, the block latches the address, length and direction.
  - cmd_len=0 -> go to DONE. No bus cycle is issued.
  - Otherwise -> go to READ or WRITE. The first avm_read or avm_write is asserted in the cycle after accept.
- READ: the next read is issued when words_left>0 and in_flight+fifo_count<FIFO_DEPTH.
  - Once asserted, avm_read, avm_address and avm_byteenable hold stable while avm_waitrequest=1.
  - A read is accepted when avm_read & ~avm_waitrequest. On accept: address+1, words_left-1, in_flight+1.
  - Back-to-back issue, one per cycle, is allowed.
  - After the last read is accepted -> DRAIN.
- avm_readdatavalid pushes avm_readdata into the FIFO and decrements in_flight. This holds in READ and DRAIN.
  - The credit rule guarantees the FIFO cannot overflow.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Words are delivered in issue order.
- DRAIN: -> DONE when in_flight=0 and the FIFO is empty, i.e. the last word has been popped with rd_valid & rd_ready.
- WRITE: wr_ready = ~avm_write | ~avm_waitrequest, and additionally requires that words remain to accept.
  - A transfer on wr_valid & wr_ready loads avm_writedata and the next address, and sets avm_write=1.
  - avm_write, avm_address and avm_writedata hold stable while avm_waitrequest=1.
  - When a write completes (~avm_waitrequest) and no new word is loaded, avm_write drops to 0.
  - Full throughput is one word per cycle with waitrequest=0.
  - After the last write completes -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. cmd_ready is 0 in DONE and returns to 1 in IDLE.
- Address arithmetic: modulo 2^ADDR_W, so 0xFFF+1 wraps to 0x000. The block performs no depth check.
- Length arithmetic: unsigned. Commands are never queued; cmd_valid outside IDLE is ignored.
- avm_read and avm_write are never asserted in the same cycle.
- avm_readdatavalid in IDLE or WRITE is ignored. The slave must not generate it.
- Reset mid-operation: all state returns to reset values immediately. Read data still in flight is discarded, and no done pulse is generated.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> outputs immediately at reset values; cmd_ready=1 after release.
- Read 4 words from 0x010, rd_ready=1, waitrequest=0, readdatavalid 1 cycle after accept, memory word = address -> avm_address sequence 0x010..0x013 on consecutive cycles; rd_data 0x10,0x11,0x12,0x13; done pulses once after the last pop.
- Read 8 words from 0x000, FIFO_DEPTH=4, rd_ready held low for 10 cycles -> exactly 4 reads issued, then avm_read stays low; releasing rd_ready yields all 8 words in order with no loss.
- Write 3 words (0xA, 0xB, 0xC) to 0x100, waitrequest high for 2 cycles on the second write -> address 0x101 and data 0xB held stable; wr_ready=0 during the stall; done pulses after the 0x102 write completes.
- Wrap: read 2 words from 0xFFF -> avm_address 0xFFF then 0x000.
- cmd_len=0 -> done pulses at accept+1; avm_read and avm_write never asserted. Back-to-back: cmd_valid held high with a second command -> second command accepted only after DONE, when back in IDLE.
